// File: rtl/register_bank_pkg.sv
// register_bank_pkg
// Shared definitions for the register bank slice: default widths, the
// register count derived from the address width, the hardwired zero-register
// index and the register word type.
package register_bank_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;

    // Always a power of two, so every address decodes to a real register.
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;

    typedef logic [DATA_WIDTH-1:0] reg_word_t;

endpackage : register_bank_pkg

// File: rtl/register_bank_if.sv
// register_bank_if
// Bundles the write and read port signals of the register bank.
//   we          write enable, active high
//   write_addr  register index to write
//   write_data  value to write
//   read_addr   register index to read
//   read_data   contents of the selected register (combinational)
// Modports:
//   master  decode/control side: drives the addresses, data and enable
//   slave   register bank side: drives read_data
interface register_bank_if #(
    parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_bank_pkg::ADDR_WIDTH
);

    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output we,
        output write_addr,
        output write_data,
        output read_addr,
        input  read_data
    );

    modport slave (
        input  we,
        input  write_addr,
        input  write_data,
        input  read_addr,
        output read_data
    );

endinterface : register_bank_if

// File: rtl/register_bank_cell.sv
// register_bank_cell
// One storage word of the register bank: a DATA_WIDTH register with a
// synchronous active-low clear and a load enable.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low clear (wins over load)
//   load   capture d on the next rising edge
//   d      data to capture
//   q      stored value
module register_bank_cell #(
    parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: clocked state uses non-blocking assignments so every cell samples
    // its inputs before any of them update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : register_bank_cell

// File: rtl/register_bank.sv
// register_bank
// General-purpose register file: NUM_REGS words of DATA_WIDTH bits with one
// synchronous write port and one combinational read port. Register 0 is a
// hardwired zero; writes to it are accepted and discarded.
//   clk    system clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset, clears registers 1..NUM_REGS-1
//   bus    register_bank_if slave port (we, write_addr, write_data,
//          read_addr in; read_data out)
// There is no write-to-read bypass: a read of the register being written
// shows the old value until the edge that performs the write.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_bank_pkg::ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    register_bank_if.slave  bus
);

    localparam int REG_COUNT = 2 ** ADDR_WIDTH;

    // Index 0 has no storage; it is tied to zero below.
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
    logic [REG_COUNT-1:1]                 write_sel;

    // One-hot write decode. Address 0 has no select line, which is what
    // makes writes to the zero register vanish.
    // NOTE: every bit gets a default before the loop so no latch is inferred.
    always_comb begin
        write_sel = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            write_sel[i] = bus.we && (bus.write_addr == ADDR_WIDTH'(i));
        end
    end

    assign regs[0] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_cell
        register_bank_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (write_sel[g]),
            .d     (bus.write_data),
            .q     (regs[g])
        );
    end

    // Combinational read with an explicit zero-register override.
    assign bus.read_data = (bus.read_addr == ZERO_REG_ADDR[ADDR_WIDTH-1:0])
                         ? '0
                         : regs[bus.read_addr];

endmodule : register_bank

// File: tb/tb_register_bank.sv
// tb_register_bank
// Directed self-checking bench for register_bank. Expected register contents
// are kept in a small bench-side model updated by each write.
module tb_register_bank;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic clk;
    logic rst_n;

    register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    logic [DW-1:0] model [NR];

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then step off it before touching anything.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input int addr,
                              input logic [DW-1:0] exp);
        bus.read_addr = AW'(addr);
        #1;
        check($sformatf("%s r%0d", tag, addr), bus.read_data, exp);
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] data);
        bus.we         = 1'b1;
        bus.write_addr = AW'(addr);
        bus.write_data = data;
        tick();
        bus.we = 1'b0;
        if (addr != 0) model[addr] = data;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            read_check(tag, i, model[i]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        bus.we         = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.read_addr  = '0;

        // Reset held for two edges, then every address reads zero.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_all("reset");

        // Basic write/read.
        do_write(3, 8'hAA);
        read_check("wr3", 3, 8'hAA);
        do_write(5, 8'h55);
        read_check("wr5", 5, 8'h55);
        read_check("hold3", 3, 8'hAA);

        // Zero register discards writes; nothing else moves.
        do_write(0, 8'hFF);
        read_check("zero", 0, 8'h00);
        check_all("after_zero_wr");

        // Write enable low: register 2 must not change over several edges.
        bus.we         = 1'b0;
        bus.write_addr = AW'(2);
        bus.write_data = 8'h3C;
        tick();
        tick();
        tick();
        read_check("we_gate", 2, 8'h00);

        // Same-cycle read/write: old value before the edge, new after it.
        bus.read_addr  = AW'(6);
        bus.we         = 1'b1;
        bus.write_addr = AW'(6);
        bus.write_data = 8'h81;
        #1;
        check("same_pre", bus.read_data, 8'h00);
        tick();
        check("same_post", bus.read_data, 8'h81);
        bus.write_data = 8'h7E;
        tick();
        bus.we = 1'b0;
        check("overwrite", bus.read_data, 8'h7E);
        model[6] = 8'h7E;

        // Fill 1..7 with 0x11..0x77.
        for (int i = 1; i < NR; i++) begin
            do_write(i, DW'(i * 8'h11));
        end
        check_all("fill");

        // Reset together with a write: reset wins.
        rst_n          = 1'b0;
        bus.we         = 1'b1;
        bus.write_addr = AW'(4);
        bus.write_data = 8'hEE;
        tick();
        rst_n  = 1'b1;
        bus.we = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_all("rst_wins");

        // Normal writes resume after reset.
        do_write(4, 8'hEE);
        read_check("resume", 4, 8'hEE);
        read_check("resume_other", 1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_register_bank
